// File: rtl/data_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_arbiter_pkg
// Description : Shared types for the data_ram arbiter. It holds the FSM state
//               codes, the master ids, the latched command record and the
//               address range-check helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_arbiter_pkg;

  localparam int c_ADDR_W = 32;
  localparam int c_DATA_W = 32;
  localparam int c_SEL_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_id_e;

  // Command captured at grant time and replayed onto the RAM port in ACCESS.
  typedef struct packed {
    arb_id_e               id;
    logic                  we;
    logic [c_ADDR_W-1:0]   addr;
    logic [c_SEL_W-1:0]    sel;
    logic [c_DATA_W-1:0]   wdata;
    logic                  oor;
  } arb_cmd_t;

  // The comparison runs at 34 bits so that a window ending at the top of the
  // 32-bit address space cannot wrap around.
  function automatic logic addr_out_of_range(
    input logic [c_ADDR_W-1:0] addr,
    input logic [c_ADDR_W-1:0] base,
    input logic [31:0]         depth_words
  );
    logic [c_ADDR_W+1:0] w_a;
    logic [c_ADDR_W+1:0] w_lo;
    logic [c_ADDR_W+1:0] w_hi;
    w_a  = {2'b00, addr};
    w_lo = {2'b00, base};
    w_hi = w_lo + {depth_words, 2'b00};
    return (w_a < w_lo) || (w_a >= w_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_arbiter_if
// Description : Request/response bus between one requester (CPU MEM stage or
//               debug loader) and the data_ram arbiter.
// Signals     : req/we/addr/sel/wdata : requester -> arbiter
//               gnt/ack/err           : arbiter   -> requester
// Modports    : master (requester side), slave (arbiter side)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_arbiter_if;
  import data_ram_arbiter_pkg::*;

  logic                req;
  logic                we;
  logic [c_ADDR_W-1:0] addr;
  logic [c_SEL_W-1:0]  sel;
  logic [c_DATA_W-1:0] wdata;
  logic                gnt;
  logic                ack;
  logic                err;

  modport master (
    output req, we, addr, sel, wdata,
    input  gnt, ack, err
  );

  modport slave (
    input  req, we, addr, sel, wdata,
    output gnt, ack, err
  );

endinterface
`default_nettype wire

// File: rtl/data_ram_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_arbiter_arb_rr2
// Description : Two-way arbiter with a one-hot combinational grant.
//               mode_i=1 : M0 has fixed priority, and a starvation guard
//                          forces M1 to win after STARVE_MAX lost contests.
//               mode_i=0 : round-robin against the last grant.
// Ports       : clk_i, rst_ni   clock, async active-low reset
//               req_i[1:0]      requests (bit0 = M0, bit1 = M1)
//               mode_i          priority mode select
//               enable_i        arbitration allowed this cycle
//               gnt_o[1:0]      one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_arbiter_arb_rr2
  import data_ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       mode_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

  localparam int                 c_CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_LIM = c_CNT_W'(STARVE_MAX);

  arb_id_e            last_grant_q;
  arb_id_e            last_grant_d;
  logic [c_CNT_W-1:0] starve_cnt_q;
  logic [c_CNT_W-1:0] starve_cnt_d;

  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    if (enable_i) begin
      case (req_i)
        2'b01: gnt_o = 2'b01;
        2'b10: gnt_o = 2'b10;
        2'b11: begin
          if (mode_i) begin
            // M1 is forced through once it has lost STARVE_MAX contests.
            // Otherwise M0 wins and the loss is counted.
            if (starve_cnt_q >= c_STARVE_LIM) begin
              gnt_o = 2'b10;
            end else begin
              gnt_o        = 2'b01;
              starve_cnt_d = starve_cnt_q + c_CNT_W'(1);
            end
          end else begin
            gnt_o = (last_grant_q == ARB_M0) ? 2'b10 : 2'b01;
          end
        end
        default: ;
      endcase
    end
    if (gnt_o[1]) begin
      last_grant_d = ARB_M1;
      starve_cnt_d = '0;
    end else if (gnt_o[0]) begin
      last_grant_d = ARB_M0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= ARB_M1;
      starve_cnt_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_arbiter
// Description : Shares the single data_ram port between the CPU MEM stage
//               (M0) and the debug/loader port (M1). Each grant latches a
//               command, which is replayed onto the RAM port for one ACCESS
//               cycle and acknowledged in the following RESP cycle.
//               Latency is grant in cycle N, ack in cycle N+2.
// Ports       : clk_i, rst_ni     clock, async active-low reset
//               m0_if, m1_if      requester buses (slave side)
//               rdata_o           read data, valid with a read ack
//               ram_ce_o/ram_we_o RAM chip/write enable
//               ram_addr_o        RAM byte address
//               ram_sel_o         RAM byte enables
//               ram_wdata_o       RAM write data
//               ram_rdata_i       RAM read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter bit          CPU_PRIO    = 1'b1,
  parameter int          STARVE_MAX  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  data_ram_arbiter_if.slave   m0_if,
  data_ram_arbiter_if.slave   m1_if,
  output logic [c_DATA_W-1:0] rdata_o,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [c_ADDR_W-1:0] ram_addr_o,
  output logic [c_SEL_W-1:0]  ram_sel_o,
  output logic [c_DATA_W-1:0] ram_wdata_o,
  input  logic [c_DATA_W-1:0] ram_rdata_i
);

  localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

  arb_state_e          state_q;
  arb_cmd_t            cmd_q;
  logic                ram_ce_q;
  logic                ram_we_q;
  logic                ack0_q;
  logic                ack1_q;
  logic                err_q;
  logic [c_DATA_W-1:0] rdata_q;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_arb_en;
  arb_cmd_t            w_new_cmd;

  assign w_req = {m1_if.req, m0_if.req};

  // Reset is folded in so that the combinational grant is also forced low
  // while rst_ni is asserted.
  assign w_arb_en = rst_ni && ((state_q == ARB_IDLE) || (state_q == ARB_RESP));

  data_ram_arbiter_arb_rr2 #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (w_req),
    .mode_i   (CPU_PRIO),
    .enable_i (w_arb_en),
    .gnt_o    (w_gnt)
  );

  // Pick the winner's command. The range check runs here, before the
  // command is latched, so that ram_ce can be registered for ACCESS.
  always_comb begin
    w_new_cmd = '0;
    if (w_gnt[1]) begin
      w_new_cmd.id    = ARB_M1;
      w_new_cmd.we    = m1_if.we;
      w_new_cmd.addr  = m1_if.addr;
      w_new_cmd.sel   = m1_if.sel;
      w_new_cmd.wdata = m1_if.wdata;
    end else begin
      w_new_cmd.id    = ARB_M0;
      w_new_cmd.we    = m0_if.we;
      w_new_cmd.addr  = m0_if.addr;
      w_new_cmd.sel   = m0_if.sel;
      w_new_cmd.wdata = m0_if.wdata;
    end
    w_new_cmd.oor = addr_out_of_range(w_new_cmd.addr, BASE_ADDR, c_DEPTH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_IDLE;
      cmd_q    <= '0;
      ram_ce_q <= 1'b0;
      ram_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE, ARB_RESP: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          err_q  <= 1'b0;
          if (|w_gnt) begin
            cmd_q    <= w_new_cmd;
            ram_ce_q <= !w_new_cmd.oor;
            ram_we_q <= !w_new_cmd.oor && w_new_cmd.we;
            state_q  <= ARB_ACCESS;
          end else begin
            state_q  <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          ack0_q   <= (cmd_q.id == ARB_M0);
          ack1_q   <= (cmd_q.id == ARB_M1);
          err_q    <= cmd_q.oor;
          // Out-of-range commands clear rdata. Writes leave it untouched.
          if (cmd_q.oor) begin
            rdata_q <= '0;
          end else if (!cmd_q.we) begin
            rdata_q <= ram_rdata_i;
          end
          state_q  <= ARB_RESP;
        end
        default: begin
          ram_ce_q <= 1'b0;
          ram_we_q <= 1'b0;
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= ARB_IDLE;
        end
      endcase
    end
  end

  assign m0_if.gnt   = w_gnt[0];
  assign m1_if.gnt   = w_gnt[1];
  assign m0_if.ack   = ack0_q;
  assign m1_if.ack   = ack1_q;
  assign m0_if.err   = err_q && ack0_q;
  assign m1_if.err   = err_q && ack1_q;

  assign rdata_o     = rdata_q;
  assign ram_ce_o    = ram_ce_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = cmd_q.addr;
  assign ram_sel_o   = cmd_q.sel;
  assign ram_wdata_o = cmd_q.wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_arbiter
// Description : Self-checking bench for data_ram_arbiter. Instance dut_p uses
//               CPU priority and is backed by a byte-enable RAM. Instance
//               dut_r uses round-robin and returns ~addr as its read data.
//               Expected values come from a word-array golden memory and
//               from the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_arbiter;

  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam int          DEPTH  = 1024;
  localparam int          STARVE = 4;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  data_ram_arbiter_if p_m0 ();
  data_ram_arbiter_if p_m1 ();
  data_ram_arbiter_if r_m0 ();
  data_ram_arbiter_if r_m1 ();

  logic [31:0] p_rdata, p_ram_addr, p_ram_wdata, p_ram_rdata;
  logic [31:0] r_rdata, r_ram_addr, r_ram_wdata, r_ram_rdata;
  logic        p_ram_ce, p_ram_we, r_ram_ce, r_ram_we;
  logic [3:0]  p_ram_sel, r_ram_sel;

  data_ram_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .CPU_PRIO(1'b1), .STARVE_MAX(STARVE)) dut_p (
    .clk_i(clk), .rst_ni(rst_ni), .m0_if(p_m0), .m1_if(p_m1), .rdata_o(p_rdata),
    .ram_ce_o(p_ram_ce), .ram_we_o(p_ram_we), .ram_addr_o(p_ram_addr), .ram_sel_o(p_ram_sel),
    .ram_wdata_o(p_ram_wdata), .ram_rdata_i(p_ram_rdata));

  data_ram_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .CPU_PRIO(1'b0), .STARVE_MAX(STARVE)) dut_r (
    .clk_i(clk), .rst_ni(rst_ni), .m0_if(r_m0), .m1_if(r_m1), .rdata_o(r_rdata),
    .ram_ce_o(r_ram_ce), .ram_we_o(r_ram_we), .ram_addr_o(r_ram_addr), .ram_sel_o(r_ram_sel),
    .ram_wdata_o(r_ram_wdata), .ram_rdata_i(r_ram_rdata));

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // data_ram stand-in for dut_p: combinational read, byte-enabled write.
  logic [31:0] mem  [0:DEPTH-1];
  logic [31:0] gold [0:DEPTH-1];
  logic [31:0] p_off;
  assign p_off       = p_ram_addr - BASE;
  assign p_ram_rdata = mem[p_off[11:2]];
  assign r_ram_rdata = ~r_ram_addr;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (p_ram_ce && p_ram_we) mem[p_off[11:2]] = merge(mem[p_off[11:2]], p_ram_wdata, p_ram_sel);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_p(input int m, input logic req, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
    if (m == 0) begin
      p_m0.req = req; p_m0.we = we; p_m0.addr = a; p_m0.sel = s; p_m0.wdata = d;
    end else begin
      p_m1.req = req; p_m1.we = we; p_m1.addr = a; p_m1.sel = s; p_m1.wdata = d;
    end
  endtask

  task automatic drive_r(input int m, input logic req, input logic [31:0] a);
    if (m == 0) begin
      r_m0.req = req; r_m0.we = 1'b0; r_m0.addr = a; r_m0.sel = 4'hF; r_m0.wdata = 32'h0;
    end else begin
      r_m1.req = req; r_m1.we = 1'b0; r_m1.addr = a; r_m1.sel = 4'hF; r_m1.wdata = 32'h0;
    end
  endtask

  function automatic logic p_gnt(input int m); return (m == 0) ? p_m0.gnt : p_m1.gnt; endfunction
  function automatic logic p_ack(input int m); return (m == 0) ? p_m0.ack : p_m1.ack; endfunction
  function automatic logic p_err(input int m); return (m == 0) ? p_m0.err : p_m1.err; endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    drive_p(0, 0, 0, 32'h0, 4'h0, 32'h0);
    drive_p(1, 0, 0, 32'h0, 4'h0, 32'h0);
    drive_r(0, 0, 32'h0);
    drive_r(1, 0, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic chk_p_zero(input string tag);
    chk({tag, "_gnt"},   {30'h0, p_m1.gnt, p_m0.gnt}, 32'h0);
    chk({tag, "_ack"},   {30'h0, p_m1.ack, p_m0.ack}, 32'h0);
    chk({tag, "_err"},   {30'h0, p_m1.err, p_m0.err}, 32'h0);
    chk({tag, "_cewe"},  {30'h0, p_ram_ce, p_ram_we}, 32'h0);
    chk({tag, "_addr"},  p_ram_addr, 32'h0);
    chk({tag, "_sel"},   {28'h0, p_ram_sel}, 32'h0);
    chk({tag, "_wdata"}, p_ram_wdata, 32'h0);
    chk({tag, "_rdata"}, p_rdata, 32'h0);
  endtask

  // One complete transaction on dut_p. It is entered just after a negedge
  // and returns at negedge+1 of the RESP cycle.
  task automatic p_txn(input int m, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    logic        oor;
    int          idx;
    int          waited;
    logic [31:0] exp_rd;
    oor = (a < BASE) || (a >= BASE + 32'(4 * DEPTH));
    idx = int'((a - BASE) >> 2);
    drive_p(m, 1, we, a, s, d);
    waited = 0;
    #1;
    while (!p_gnt(m) && waited < 4) begin
      @(negedge clk); #1; waited++;
    end
    chk("gnt_latency", 32'(waited), 32'h0);
    if (!p_gnt(m)) begin
      drive_p(m, 0, we, a, s, d);
      return;
    end
    chk("gnt_other", {31'h0, p_gnt(1 - m)}, 32'h0);
    @(posedge clk); #1;
    drive_p(m, 0, we, a, s, d);
    @(negedge clk); #1;                       // ACCESS cycle
    chk("access_ce", {31'h0, p_ram_ce}, {31'h0, !oor});
    chk("access_ack", {31'h0, p_ack(m)}, 32'h0);
    if (!oor) begin
      chk("access_we",    {31'h0, p_ram_we}, {31'h0, we});
      chk("access_addr",  p_ram_addr, a);
      chk("access_sel",   {28'h0, p_ram_sel}, {28'h0, s});
      chk("access_wdata", p_ram_wdata, d);
    end
    @(negedge clk); #1;                       // RESP cycle
    chk("resp_ack",       {31'h0, p_ack(m)}, 32'h1);
    chk("resp_ack_other", {31'h0, p_ack(1 - m)}, 32'h0);
    chk("resp_err",       {31'h0, p_err(m)}, {31'h0, oor});
    chk("resp_ce_off",    {30'h0, p_ram_ce, p_ram_we}, 32'h0);
    if (!we) begin
      exp_rd = oor ? 32'h0 : gold[idx];
      chk("resp_rdata", p_rdata, exp_rd);
    end else if (!oor) begin
      gold[idx] = merge(gold[idx], d, s);
    end
  endtask

  int          m, kind, pk, rk;
  logic        twe;
  logic [31:0] ta, td;
  logic [3:0]  ts;
  logic [1:0]  pg, rg;
  int          p_id [0:31];
  int          r_id [0:31];

  initial begin
    for (int i = 0; i < DEPTH; i++) gold[i] = 32'h0;
    rst_ni = 1'b0;
    drive_p(0, 0, 0, 32'h0, 4'h0, 32'h0);
    drive_p(1, 0, 0, 32'h0, 4'h0, 32'h0);
    drive_r(0, 0, 32'h0);
    drive_r(1, 0, 32'h0);
    @(negedge clk); #1;
    chk_p_zero("reset");
    chk("reset_r_rdata", r_rdata, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Full-word write, read back, then a single-byte overwrite.
    p_txn(0, 1, 32'h0001_0004, 4'hF, 32'hDEAD_BEEF);
    p_txn(0, 0, 32'h0001_0004, 4'hF, 32'h0);
    chk("t1_rdata", p_rdata, 32'hDEAD_BEEF);
    p_txn(0, 1, 32'h0001_0004, 4'b0100, 32'h00AA_0000);
    p_txn(0, 0, 32'h0001_0004, 4'hF, 32'h0);
    chk("t2_rdata", p_rdata, 32'hDEAA_BEEF);

    // Range edges: one word below, one word past the top, and the last word.
    p_txn(1, 0, 32'h0000_FFFC, 4'hF, 32'h0);
    p_txn(1, 0, 32'h0001_1000, 4'hF, 32'h0);
    chk("t3_oor_rdata", p_rdata, 32'h0);
    p_txn(1, 0, 32'h0001_0FFC, 4'hF, 32'h0);

    // Randomized single-requester traffic against the golden memory.
    for (int t = 0; t < 40; t++) begin
      m    = int'($urandom_range(0, 1));
      twe  = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind == 0)      ta = BASE - 32'(4 * $urandom_range(1, 64));
      else if (kind == 1) ta = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
      else if (kind == 2) ta = BASE + 32'(4 * (DEPTH - 1));
      else                ta = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      ts = (kind == 3) ? 4'h0 : 4'($urandom_range(0, 15));
      td = $urandom;
      p_txn(m, twe, ta, ts, td);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    // Both masters held high. The priority instance grants M0 four times,
    // then M1. The round-robin instance alternates, starting with M0.
    do_reset();
    drive_p(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0);
    drive_p(1, 1, 0, BASE + 32'h20, 4'hF, 32'h0);
    drive_r(0, 1, BASE + 32'h10);
    drive_r(1, 1, BASE + 32'h20);
    pk = 0;
    rk = 0;
    for (int c = 0; c < 22; c++) begin
      #1;
      pg = {p_m1.gnt, p_m0.gnt};
      rg = {r_m1.gnt, r_m0.gnt};
      p_id[c] = -1;
      r_id[c] = -1;
      chk("t4_gnt_slot", {31'h0, pg != 2'b00}, {31'h0, (c % 2) == 0});
      if (pg != 2'b00) begin
        chk("t4_winner", {30'h0, pg}, ((pk % (STARVE + 1)) == STARVE) ? 32'h2 : 32'h1);
        p_id[c] = pg[1] ? 1 : 0;
        pk++;
      end
      chk("t5_gnt_slot", {31'h0, rg != 2'b00}, {31'h0, (c % 2) == 0});
      if (rg != 2'b00) begin
        chk("t5_winner", {30'h0, rg}, ((rk % 2) == 1) ? 32'h2 : 32'h1);
        r_id[c] = rg[1] ? 1 : 0;
        rk++;
      end
      if (c >= 2) begin
        chk("t4_ack", {30'h0, p_m1.ack, p_m0.ack},
            (p_id[c-2] < 0) ? 32'h0 : ((p_id[c-2] == 1) ? 32'h2 : 32'h1));
        chk("t5_ack", {30'h0, r_m1.ack, r_m0.ack},
            (r_id[c-2] < 0) ? 32'h0 : ((r_id[c-2] == 1) ? 32'h2 : 32'h1));
        if (r_id[c-2] >= 0)
          chk("t5_rdata", r_rdata, (r_id[c-2] == 1) ? ~(BASE + 32'h20) : ~(BASE + 32'h10));
      end
      @(negedge clk);
    end
    chk("t4_grants", 32'(pk), 32'd11);
    chk("t5_grants", 32'(rk), 32'd11);

    // Reset in the middle of a read: outputs clear at once, and no stale ack
    // follows the release.
    do_reset();
    p_txn(0, 1, BASE + 32'h8, 4'hF, 32'h1234_5678);
    p_txn(0, 0, BASE + 32'h8, 4'hF, 32'h0);
    chk("t6_pre_rdata", p_rdata, 32'h1234_5678);
    @(negedge clk);
    drive_p(0, 1, 0, BASE + 32'h8, 4'hF, 32'h0);
    #1;
    chk("t6_gnt", {31'h0, p_m0.gnt}, 32'h1);
    @(posedge clk); #1;
    drive_p(0, 0, 0, BASE + 32'h8, 4'hF, 32'h0);
    #1;
    chk("t6_access_ce", {31'h0, p_ram_ce}, 32'h1);
    @(negedge clk);
    rst_ni = 1'b0;
    drive_p(1, 1, 0, BASE + 32'h8, 4'hF, 32'h0);
    #1;
    chk_p_zero("t6_rst");
    drive_p(1, 0, 0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t6_no_ack", {30'h0, p_m1.ack, p_m0.ack}, 32'h0);
      @(negedge clk);
    end
    p_txn(0, 0, BASE + 32'h8, 4'hF, 32'h0);
    chk("t6_post_rdata", p_rdata, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
